// File: rtl/axi4_sram_slave_if.sv
// AXI4 slave-side bundle for the SRAM responder: AW, W, B, AR and R channels.
// slave modport is used by axi4_sram_slave, master modport by the requester.
interface axi4_sram_slave_if #(
   parameter int ID_WIDTH   = 8,
   parameter int ADDR_WIDTH = 32
);
   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awvalid;
   logic                  awready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;
   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;
   logic [ID_WIDTH-1:0]   rid;
   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 responder over a word-addressed SRAM with independent write/read engines.
// Ports: clk, rst (sync, active-high), s_axi (slave modport of axi4_sram_slave_if).
module axi4_sram_slave #(
   parameter int ID_WIDTH   = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_WORDS  = 4096
) (
   input  logic             clk,
   input  logic             rst,
   axi4_sram_slave_if.slave s_axi
);
   localparam int AW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA} r_state_e;

   logic [31:0] mem [MEM_WORDS];
   logic [31:0] rdata_q;

   w_state_e            w_state_q, w_state_d;
   logic [ID_WIDTH-1:0] w_id_q, w_id_d;
   logic [AW-1:0]       w_addr_q, w_addr_d;
   logic [7:0]          w_len_q, w_len_d;
   logic [7:0]          w_cnt_q, w_cnt_d;
   logic                w_fixed_q, w_fixed_d;
   logic                w_bad_q, w_bad_d;
   logic                w_err_q, w_err_d;
   logic                awready_q, awready_d;
   logic                wready_q, wready_d;
   logic                bvalid_q, bvalid_d;
   logic [1:0]          bresp_q, bresp_d;

   r_state_e            r_state_q, r_state_d;
   logic [ID_WIDTH-1:0] r_id_q, r_id_d;
   logic [AW-1:0]       r_addr_q, r_addr_d;
   logic [7:0]          r_len_q, r_len_d;
   logic [7:0]          r_cnt_q, r_cnt_d;
   logic                r_fixed_q, r_fixed_d;
   logic                r_bad_q, r_bad_d;
   logic                arready_q, arready_d;
   logic                rvalid_q, rvalid_d;
   logic                rlast_q, rlast_d;
   logic [1:0]          rresp_q, rresp_d;

   logic          mem_we;
   logic [AW-1:0] rd_idx;
   logic          w_last;

   // Address bits outside the word index are intentionally ignored (aliasing).
   logic unused_addr;
   assign unused_addr = ^{s_axi.awaddr[ADDR_WIDTH-1:AW+2], s_axi.awaddr[1:0],
                          s_axi.araddr[ADDR_WIDTH-1:AW+2], s_axi.araddr[1:0]};

   // Write engine
   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_fixed_d = w_fixed_q;
      w_bad_d   = w_bad_q;
      w_err_d   = w_err_q;
      bresp_d   = bresp_q;
      mem_we    = 1'b0;
      w_last    = (w_cnt_q == w_len_q);
      unique case (w_state_q)
         W_IDLE: begin
            if (awready_q && s_axi.awvalid) begin
               w_id_d    = s_axi.awid;
               w_addr_d  = s_axi.awaddr[AW+1:2];
               w_len_d   = s_axi.awlen;
               w_cnt_d   = 8'd0;
               w_fixed_d = (s_axi.awburst == 2'b00);
               w_bad_d   = (s_axi.awsize != 3'b010) || s_axi.awburst[1];
               w_err_d   = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wready_q && s_axi.wvalid) begin
               mem_we   = !w_bad_q;
               w_cnt_d  = w_cnt_q + 8'd1;
               w_addr_d = w_fixed_q ? w_addr_q : w_addr_q + 1'b1;
               if (s_axi.wlast != w_last) begin
                  w_err_d = 1'b1;
               end
               if (w_last) begin
                  bresp_d   = (w_bad_q || w_err_d) ? 2'b10 : 2'b00;
                  w_state_d = W_RESP;
               end
            end
         end
         default: begin
            if (bvalid_q && s_axi.bready) begin
               w_state_d = W_IDLE;
            end
         end
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
   end

   // Read engine; rd_idx feeds the synchronous read port every cycle
   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_addr_d  = r_addr_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_fixed_d = r_fixed_q;
      r_bad_d   = r_bad_q;
      unique case (r_state_q)
         R_IDLE: begin
            if (arready_q && s_axi.arvalid) begin
               r_id_d    = s_axi.arid;
               r_addr_d  = s_axi.araddr[AW+1:2];
               r_len_d   = s_axi.arlen;
               r_cnt_d   = 8'd0;
               r_fixed_d = (s_axi.arburst == 2'b00);
               r_bad_d   = (s_axi.arsize != 3'b010) || s_axi.arburst[1];
               r_state_d = R_DATA;
            end
         end
         default: begin
            if (rvalid_q && s_axi.rready) begin
               if (r_cnt_q == r_len_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_cnt_d  = r_cnt_q + 8'd1;
                  r_addr_d = r_fixed_q ? r_addr_q : r_addr_q + 1'b1;
               end
            end
         end
      endcase
      // Stalled beats re-read their own word, so the output register holds.
      rd_idx    = r_addr_d;
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
      rlast_d   = rvalid_d && (r_cnt_d == r_len_d);
      rresp_d   = (rvalid_d && r_bad_d) ? 2'b10 : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_fixed_q <= 1'b0;
         w_bad_q   <= 1'b0;
         w_err_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_fixed_q <= 1'b0;
         r_bad_q   <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= 2'b00;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_fixed_q <= w_fixed_d;
         w_bad_q   <= w_bad_d;
         w_err_q   <= w_err_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_fixed_q <= r_fixed_d;
         r_bad_q   <= r_bad_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rresp_q   <= rresp_d;
      end
   end

   // Read-first SRAM: the read sees the array before this edge's write.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (s_axi.wstrb[b]) begin
               mem[w_addr_q][8*b +: 8] <= s_axi.wdata[8*b +: 8];
            end
         end
      end
      rdata_q <= mem[rd_idx];
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bid     = w_id_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rid     = r_id_q;
   assign s_axi.rdata   = r_bad_q ? 32'd0 : rdata_q;
   assign s_axi.rlast   = rlast_q;
   assign s_axi.rresp   = rresp_q;
endmodule
